// File: rtl/rtoc_pkg.sv
// rtl/rtoc_pkg.sv - shared widths and event packing for the real-time output core
package rtoc_pkg;

  localparam int TS_WIDTH  = 64;
  localparam int BUS_WIDTH = 128;

  // Event layout on the bus: timestamp in the upper half, zero-extended payload below.
  function automatic logic [BUS_WIDTH-1:0] pack_event(input logic [TS_WIDTH-1:0] ts,
                                                       input logic [63:0]         data);
    return {ts, data};
  endfunction

endpackage

// File: rtl/rtoc_sync_fifo.sv
// rtl/rtoc_sync_fifo.sv - single-clock first-word-fall-through FIFO with occupancy
module rtoc_sync_fifo #(
  parameter int WIDTH      = 65,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  do_rd;

  // A read of an empty FIFO is ignored so the level can never underflow.
  assign do_rd = rd_en && (level_q != '0);

  // Pointer and occupancy update; pointers wrap naturally at the depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (srst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, do_rd})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    level_q  <= level_d;
  end

  // Storage array, left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !srst) mem[wr_ptr_q] <= wr_data;
  end

  assign dout  = mem[rd_ptr_q];
  assign level = level_q;
  assign empty = (level_q == '0);

endmodule

// File: rtl/rtoc_core_param.sv
// rtl/rtoc_core_param.sv - timestamped event buffer released on counter match
module rtoc_core_param
  import rtoc_pkg::*;
#(
  parameter int DATA_WIDTH     = 1,
  parameter int DEPTH_LOG2     = 10,
  parameter int FULL_THRESHOLD = 1000,
  parameter int LATE_POLICY    = 0,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     auto_start,
  input  logic                     flush,
  input  logic                     error_clear,
  input  logic                     write,
  input  logic [BUS_WIDTH-1:0]     fifo_din,
  input  logic [TS_WIDTH-1:0]      counter,
  output logic                     counter_matched,
  output logic [BUS_WIDTH-1:0]     rto_out,
  output logic                     timestamp_error,
  output logic                     overflow_error,
  output logic [BUS_WIDTH-1:0]     timestamp_error_data,
  output logic [BUS_WIDTH-1:0]     overflow_error_data,
  output logic [ERR_CNT_WIDTH-1:0] timestamp_error_count,
  output logic [ERR_CNT_WIDTH-1:0] overflow_error_count,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH_LOG2:0]      level
);

  localparam int ENTRY_W = TS_WIDTH + DATA_WIDTH;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(FULL_THRESHOLD);

  logic [ENTRY_W-1:0]    fifo_dout;
  logic [DEPTH_LOG2:0]   fifo_level;
  logic                  fifo_empty;
  logic [TS_WIDTH-1:0]   head_ts;
  logic [63:0]           head_data, din_data;
  logic [BUS_WIDTH-1:0]  head_event, din_event;
  logic                  wr_accept, wr_reject, cmp_en, hit, late, pop, release_out;
  logic                  unused_din;

  logic                     counter_matched_q, counter_matched_d;
  logic [BUS_WIDTH-1:0]     rto_out_q, rto_out_d;
  logic                     ts_err_q, ts_err_d, ov_err_q, ov_err_d;
  logic [BUS_WIDTH-1:0]     ts_err_data_q, ts_err_data_d, ov_err_data_q, ov_err_data_d;
  logic [ERR_CNT_WIDTH-1:0] ts_err_cnt_q, ts_err_cnt_d, ov_err_cnt_q, ov_err_cnt_d;

  // Payload bits above DATA_WIDTH are ignored by design.
  assign unused_din = ^fifo_din;

  rtoc_sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .srst    (reset | flush),
    .wr_en   (wr_accept),
    .wr_data ({fifo_din[BUS_WIDTH-1 -: TS_WIDTH], fifo_din[DATA_WIDTH-1:0]}),
    .rd_en   (pop),
    .dout    (fifo_dout),
    .level   (fifo_level),
    .empty   (fifo_empty)
  );

  // Zero-extend payloads so events are packed identically from bus and FIFO head.
  always_comb begin
    din_data  = '0;
    head_data = '0;
    din_data[DATA_WIDTH-1:0]  = fifo_din[DATA_WIDTH-1:0];
    head_data[DATA_WIDTH-1:0] = fifo_dout[DATA_WIDTH-1:0];
  end

  assign head_ts    = fifo_dout[ENTRY_W-1 -: TS_WIDTH];
  assign head_event = pack_event(head_ts, head_data);
  assign din_event  = pack_event(fifo_din[BUS_WIDTH-1 -: TS_WIDTH], din_data);

  assign full      = (fifo_level >= FULL_LVL);
  assign empty     = fifo_empty;
  assign level     = fifo_level;
  assign wr_accept = write && !full && !flush;
  assign wr_reject = write &&  full && !flush;

  // A flushing cycle neither pops nor releases, so rto_out and errors stay untouched.
  assign cmp_en      = auto_start && !fifo_empty && !flush;
  assign hit         = cmp_en && (head_ts == counter);
  assign late        = cmp_en && (head_ts <  counter);
  assign pop         = hit || late;
  assign release_out = hit || (late && (LATE_POLICY != 0));

  // Output and error bookkeeping; error_clear applies first so a same-cycle error wins.
  always_comb begin
    counter_matched_d = release_out;
    rto_out_d         = release_out ? head_event : rto_out_q;

    ts_err_d      = error_clear ? 1'b0 : ts_err_q;
    ts_err_cnt_d  = error_clear ? '0   : ts_err_cnt_q;
    ts_err_data_d = error_clear ? '0   : ts_err_data_q;
    ov_err_d      = error_clear ? 1'b0 : ov_err_q;
    ov_err_cnt_d  = error_clear ? '0   : ov_err_cnt_q;
    ov_err_data_d = error_clear ? '0   : ov_err_data_q;

    if (late) begin
      if (!ts_err_d) ts_err_data_d = head_event;
      if (!(&ts_err_cnt_d)) ts_err_cnt_d = ts_err_cnt_d + 1'b1;
      ts_err_d = 1'b1;
    end
    if (wr_reject) begin
      if (!ov_err_d) ov_err_data_d = din_event;
      if (!(&ov_err_cnt_d)) ov_err_cnt_d = ov_err_cnt_d + 1'b1;
      ov_err_d = 1'b1;
    end
  end

  // Registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_matched_q <= 1'b0;
      rto_out_q         <= '0;
      ts_err_q          <= 1'b0;
      ts_err_cnt_q      <= '0;
      ts_err_data_q     <= '0;
      ov_err_q          <= 1'b0;
      ov_err_cnt_q      <= '0;
      ov_err_data_q     <= '0;
    end else begin
      counter_matched_q <= counter_matched_d;
      rto_out_q         <= rto_out_d;
      ts_err_q          <= ts_err_d;
      ts_err_cnt_q      <= ts_err_cnt_d;
      ts_err_data_q     <= ts_err_data_d;
      ov_err_q          <= ov_err_d;
      ov_err_cnt_q      <= ov_err_cnt_d;
      ov_err_data_q     <= ov_err_data_d;
    end
  end

  assign counter_matched       = counter_matched_q;
  assign rto_out               = rto_out_q;
  assign timestamp_error       = ts_err_q;
  assign timestamp_error_count = ts_err_cnt_q;
  assign timestamp_error_data  = ts_err_data_q;
  assign overflow_error        = ov_err_q;
  assign overflow_error_count  = ov_err_cnt_q;
  assign overflow_error_data   = ov_err_data_q;

endmodule
